instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Sits directly downstream of the program counter; consumes the registered fetch address and drives the instruction-memory request/acknowledge bus.
- Holds the returned word in an instruction register and presents it to decode with a valid/ready handshake.
- Splits out field_addr16 and field_addr26 for the address extender and PC.
- Raises stall so the PC holds its value while a fetch is outstanding.

Parameters:
- ADDR_W, 32, fetch/memory address width
- DATA_W, 32, instruction word width
- TIMEOUT_CYC, 15, max cycles in REQ waiting for imem_ack before abort (minimum 1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low
- fetch_addr  in  ADDR_W  next instruction address from PC
- fetch_req  in  1  request fetch of fetch_addr this cycle
- flush  in  1  jump/branch taken; discard any in-flight or held instruction
- stall  out  1  PC must hold while high
- imem_req  out  1  memory request, held until ack or timeout
- imem_addr  out  ADDR_W  registered request address, bits [1:0] forced 00
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  DATA_W  instruction word, sampled only when imem_ack=1
- instr  out  DATA_W  instruction register
- instr_valid  out  1  instr holds a live instruction
- instr_ready  in  1  decode accepts instr this cycle
- opcode  out  6  instr[31:26]
- field_addr16  out  16  instr[15:0]
- field_addr26  out  26  instr[25:0]
- bus_err  out  1  sticky: fetch timed out
- align_err  out  1  sticky misalignment flag (see Optional Feature)

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE; imem_req=0, imem_addr=0, instr=0, instr_valid=0, bus_err=0, align_err=0, timeout counter=0. Reset overrides everything, including an in-flight fetch; a late imem_ack after reset is ignored.
- States: IDLE, REQ, DRAIN, HOLD.
- Accept condition: fetch_req=1 and (state=IDLE, or state=HOLD with instr_ready=1 and flush=0).
- IDLE: on accept, latch imem_addr={fetch_addr[ADDR_W-1:2],2'b00}, go to REQ; imem_req=1 from the next cycle.
- REQ:
  - imem_ack=1 with flush=0: instr<=imem_rdata, instr_valid<=1, go to HOLD. Latency is ack cycle + 1.
  - flush=1 without ack: go to DRAIN.
  - flush=1 with ack in the same cycle: drop the data, go to IDLE.
  - counter reaches TIMEOUT_CYC without ack: imem_req<=0, bus_err<=1, go to IDLE; no instr_valid.
- DRAIN: imem_req stays high until imem_ack, then data is discarded and state goes to IDLE. The timeout applies here too.
- HOLD:
  - instr_ready=1: instr_valid<=0, then go to REQ if an accept occurs in the same cycle (back-to-back), else IDLE.
  - flush=1: instr_valid<=0, go to IDLE; any fetch_req that cycle is ignored.
- stall=1 when state∈{REQ,DRAIN} or (state=HOLD and instr_ready=0). It is combinational from state and instr_ready.
- Field outputs are combinational slices of instr and stay stable while instr_valid=1.
- Counter is 0 on entry to REQ/DRAIN and increments each waiting cycle; width is clog2(TIMEOUT_CYC+1).

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined: an accept with fetch_addr[1:0]≠00 issues no request, sets align_err=1 (sticky until reset), and the state stays/returns IDLE.
- Undefined: low bits are silently masked and align_err is tied 0.

Decomposition:
- Package mips_fetch_pkg: fetch state enum, OPCODE_MSB/LSB, ADDR16/ADDR26 field widths, INSTR_W=32.
- Sub-module fetch_timeout_counter: clear, enable, terminal-count flag; sized by TIMEOUT_CYC.

Test Plan:
- Basic fetch: fetch_req with addr=0x00000040, ack 2 cycles later with rdata=0x08000010 → imem_addr=0x40; instr_valid the cycle after ack; opcode=0x02, field_addr26=0x0000010.
- Back-to-back: hold instr_ready=1 and pulse fetch_req each HOLD → consecutive fetches 0x40, 0x44, 0x48 with no IDLE cycle; stall low only in HOLD with ready.
- Flush in REQ: flush while awaiting ack, ack later with 0xDEADBEEF → instr_valid never rises, state returns IDLE after ack.
- Timeout: never ack → after 15 cycles imem_req=0 and bus_err=1 (sticky); a new fetch_req still works.
- Reset mid-fetch: reset=0 during REQ, then ack arrives → all outputs 0, no instr_valid.
- With FETCH_ALIGN_CHECK_EN, addr=0x42 → no imem_req, align_err=1. Without it, imem_addr=0x40.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and field geometry for the MIPS-style fetch unit.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DRAIN,
        ST_HOLD
    } fetch_state_e;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int ADDR16_W   = 16;
    localparam int ADDR26_W   = 26;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Wait-cycle counter for an outstanding fetch; tc flags the last allowed cycle.
module fetch_timeout_counter
    import mips_fetch_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Abort on the cycle whose increment would reach TIMEOUT_CYC.
    assign tc = enable && (cnt_q == LAST);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: imem req/ack, instruction register, decode handshake.
// Optional FETCH_ALIGN_CHECK_EN rejects misaligned fetch addresses.
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   fetch_addr,
    input  logic                fetch_req,
    input  logic                flush,
    output logic                stall,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [DATA_W-1:0]   imem_rdata,
    output logic [DATA_W-1:0]   instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [5:0]          opcode,
    output logic [ADDR16_W-1:0] field_addr16,
    output logic [ADDR26_W-1:0] field_addr26,
    output logic                bus_err,
    output logic                align_err
);

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              imem_req_q, imem_req_d;
    logic              instr_valid_q, instr_valid_d;
    logic              bus_err_q, bus_err_d;
    logic              align_err_q, align_err_d;
    logic              accept;
    logic              waiting;
    logic              misalign;
    logic              cnt_clear;
    logic              tmo;

    assign waiting  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign misalign = ALIGN_CHK && (fetch_addr[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        imem_addr_d = imem_addr_q;
        instr_d     = instr_q;
        bus_err_d   = bus_err_q;
        align_err_d = align_err_q;
        accept      = 1'b0;
        unique case (state_q)
            ST_IDLE: accept = fetch_req;
            ST_REQ: begin
                if (imem_ack) begin
                    state_d = flush ? ST_IDLE : ST_HOLD;
                    if (!flush) instr_d = imem_rdata;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end else if (tmo) begin
                    state_d   = ST_IDLE;
                    bus_err_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    state_d = ST_IDLE;
                end else if (tmo) begin
                    state_d   = ST_IDLE;
                    bus_err_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (instr_ready) begin
                    state_d = ST_IDLE;
                    accept  = fetch_req;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            if (misalign) begin
                align_err_d = 1'b1;
                state_d     = ST_IDLE;
            end else begin
                state_d     = ST_REQ;
                imem_addr_d = {fetch_addr[ADDR_W-1:2], 2'b00};
            end
        end
        imem_req_d    = (state_d == ST_REQ) || (state_d == ST_DRAIN);
        instr_valid_d = (state_d == ST_HOLD);
        // Restart the count on every entry into REQ or DRAIN.
        cnt_clear     = !waiting || (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            imem_addr_q   <= '0;
            instr_q       <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
            align_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            bus_err_q     <= bus_err_d;
            align_err_q   <= align_err_d;
        end
    end

    fetch_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .enable(waiting),
        .tc    (tmo)
    );

    assign stall        = waiting || ((state_q == ST_HOLD) && !instr_ready);
    assign imem_req     = imem_req_q;
    assign imem_addr    = imem_addr_q;
    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign bus_err      = bus_err_q;
    assign align_err    = ALIGN_CHK ? align_err_q : 1'b0;
    assign opcode       = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign field_addr16 = instr_q[ADDR16_W-1:0];
    assign field_addr26 = instr_q[ADDR26_W-1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed fetch sequences.
module tb_instruction_fetch_unit;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TMO    = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_req = 1'b0;
    logic              flush = 1'b0;
    logic              stall;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack = 1'b0;
    logic [DATA_W-1:0] imem_rdata = '0;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [5:0]        opcode;
    logic [15:0]       field_addr16;
    logic [25:0]       field_addr26;
    logic              bus_err;
    logic              align_err;

    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_addr(fetch_addr),
        .fetch_req(fetch_req),
        .flush(flush),
        .stall(stall),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .opcode(opcode),
        .field_addr16(field_addr16),
        .field_addr26(field_addr26),
        .bus_err(bus_err),
        .align_err(align_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every decode handshake must match the oldest expected word.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h required none", instr);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", instr, e);
                chk("sb_opcode", 32'(opcode), 32'(e[31:26]));
                chk("sb_addr16", 32'(field_addr16), 32'(e[15:0]));
                chk("sb_addr26", 32'(field_addr26), 32'(e[25:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b2b_data [3];
        int n;
        b2b_data[0] = 32'h8C220004;
        b2b_data[1] = 32'hAC230008;
        b2b_data[2] = 32'h10000003;

        // Reset state
        repeat (2) tick();
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_align_err", 32'(align_err), 0);
        chk("rst_stall", 32'(stall), 0);
        reset = 1'b1;
        tick();

        // Basic fetch, ack two cycles after the request
        fetch_addr = 32'h40;
        fetch_req  = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("basic_addr", imem_addr, 32'h40);
        chk("basic_req", 32'(imem_req), 1);
        chk("basic_stall", 32'(stall), 1);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h08000010;
        exp_q.push_back(32'h08000010);
        #1;
        chk("basic_not_yet", 32'(instr_valid), 0);
        tick();
        imem_ack = 1'b0;
        chk("basic_valid", 32'(instr_valid), 1);
        chk("basic_opcode", 32'(opcode), 32'h02);
        chk("basic_addr26", 32'(field_addr26), 32'h0000010);
        chk("basic_req_drop", 32'(imem_req), 0);
        chk("basic_hold_stall", 32'(stall), 1);
        instr_ready = 1'b1;
        #1;
        chk("basic_ready_stall", 32'(stall), 0);
        tick();
        chk("basic_consumed", 32'(instr_valid), 0);

        // Back-to-back fetches 0x40, 0x44, 0x48
        fetch_addr = 32'h40;
        fetch_req  = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_addr", imem_addr, 32'(32'h40 + 4 * i));
            chk("b2b_req", 32'(imem_req), 1);
            chk("b2b_req_stall", 32'(stall), 1);
            imem_ack   = 1'b1;
            imem_rdata = b2b_data[i];
            exp_q.push_back(b2b_data[i]);
            tick();
            imem_ack = 1'b0;
            chk("b2b_valid", 32'(instr_valid), 1);
            if (i < 2) begin
                fetch_req  = 1'b1;
                fetch_addr = 32'(32'h40 + 4 * (i + 1));
            end
            #1;
            chk("b2b_hold_stall", 32'(stall), 0);
            tick();
            fetch_req = 1'b0;
        end
        chk("b2b_idle_req", 32'(imem_req), 0);

        // Flush while awaiting ack; late ack is discarded
        fetch_addr = 32'h80;
        fetch_req  = 1'b1;
        tick();
        fetch_req = 1'b0;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        chk("drain_req", 32'(imem_req), 1);
        chk("drain_stall", 32'(stall), 1);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        tick();
        imem_ack = 1'b0;
        chk("drain_done_req", 32'(imem_req), 0);
        chk("drain_no_valid", 32'(instr_valid), 0);
        chk("drain_idle_stall", 32'(stall), 0);

        // Flush and ack in the same cycle
        fetch_addr = 32'h84;
        fetch_req  = 1'b1;
        tick();
        fetch_req  = 1'b0;
        flush      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h12345678;
        tick();
        flush    = 1'b0;
        imem_ack = 1'b0;
        chk("flush_ack_valid", 32'(instr_valid), 0);
        chk("flush_ack_req", 32'(imem_req), 0);

        // Flush in HOLD drops the held word and ignores fetch_req
        instr_ready = 1'b0;
        fetch_addr  = 32'h200;
        fetch_req   = 1'b1;
        tick();
        fetch_req  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h11111111;
        tick();
        imem_ack = 1'b0;
        chk("hflush_valid_before", 32'(instr_valid), 1);
        flush      = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h204;
        tick();
        flush     = 1'b0;
        fetch_req = 1'b0;
        chk("hflush_valid", 32'(instr_valid), 0);
        chk("hflush_req", 32'(imem_req), 0);
        chk("hflush_stall", 32'(stall), 0);
        instr_ready = 1'b1;

        // Timeout: no ack at all
        fetch_addr = 32'hC0;
        fetch_req  = 1'b1;
        tick();
        fetch_req = 1'b0;
        n = 0;
        while (imem_req && n < 40) begin
            n++;
            tick();
        end
        chk("tmo_cycles", 32'(n), 32'(TMO));
        chk("tmo_req", 32'(imem_req), 0);
        chk("tmo_bus_err", 32'(bus_err), 1);
        chk("tmo_no_valid", 32'(instr_valid), 0);

        // Fetch after timeout still works; bus_err stays set
        fetch_addr = 32'h100;
        fetch_req  = 1'b1;
        tick();
        fetch_req  = 1'b0;
        chk("post_tmo_addr", imem_addr, 32'h100);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0C000020;
        exp_q.push_back(32'h0C000020);
        tick();
        imem_ack = 1'b0;
        chk("post_tmo_valid", 32'(instr_valid), 1);
        chk("post_tmo_sticky", 32'(bus_err), 1);
        tick();

        // Reset during REQ, ack arrives afterwards
        fetch_addr = 32'h140;
        fetch_req  = 1'b1;
        tick();
        fetch_req = 1'b0;
        reset     = 1'b0;
        tick();
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFFFFFF;
        tick();
        imem_ack = 1'b0;
        chk("mrst_req", 32'(imem_req), 0);
        chk("mrst_addr", imem_addr, 0);
        chk("mrst_instr", instr, 0);
        chk("mrst_valid", 32'(instr_valid), 0);
        chk("mrst_bus_err", 32'(bus_err), 0);

        // Misaligned fetch address
        fetch_addr = 32'h42;
        fetch_req  = 1'b1;
        tick();
        fetch_req = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("align_req", 32'(imem_req), 0);
        chk("align_err", 32'(align_err), 1);
        chk("align_stall", 32'(stall), 0);
        tick();
        chk("align_sticky", 32'(align_err), 1);
`else
        chk("mask_addr", imem_addr, 32'h40);
        chk("mask_req", 32'(imem_req), 1);
        chk("mask_align_err", 32'(align_err), 0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h3C010001;
        exp_q.push_back(32'h3C010001);
        tick();
        imem_ack = 1'b0;
        tick();
`endif

        repeat (2) tick();
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
